// File: rtl/sample_queue.sv
// sample_queue: circular sample buffer that replays the most recent TAPS
// samples, oldest first, to a downstream FIR stage after every new sample.
// Optional build macro SQ_OVERRUN_CNT_EN adds the 8-bit ovr_cnt output that
// counts samples arriving while a replay request is already pending.
module sample_queue #(
  parameter int DEPTH = 1024,
  parameter int TAPS  = 1021
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wrt_smpl,
  input  logic signed [15:0] new_smpl,
  output logic signed [15:0] smpl_out,
  output logic               sequencing,
  output logic               seq_done
`ifdef SQ_OVERRUN_CNT_EN
  ,
  output logic [7:0]         ovr_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TAPS + 1);
  localparam logic [CW-1:0] TAPS_C    = CW'(TAPS);
  localparam logic [CW-1:0] TAPS_M1_C = CW'(TAPS - 1);

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_SEQ  = 2'd2;

  logic signed [15:0] mem [DEPTH];

  logic [1:0]    state_reg, state_next;
  logic [AW-1:0] new_ptr_reg, new_ptr_next;
  logic [AW-1:0] old_ptr_reg, old_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] fill_cnt_reg, fill_cnt_next;
  logic [CW-1:0] rd_cnt_reg, rd_cnt_next;
  logic          pending_reg, pending_next;
  logic          last_rd_d1_reg;
  logic signed [15:0] smpl_out_reg;
  logic          sequencing_reg;
  logic          seq_done_reg;

  logic filled;
  logic rd_en;
  logic last_rd;
  logic start_seq;

  // Pointer, fill and sequencing control for the next cycle
  always_comb begin
    filled        = (fill_cnt_reg == TAPS_C);
    rd_en         = (state_reg == ST_SEQ);
    last_rd       = rd_en && (rd_cnt_reg == TAPS_M1_C);
    new_ptr_next  = wrt_smpl ? new_ptr_reg + 1'b1 : new_ptr_reg;
    // Once the window is full each new sample pushes the oldest one out
    old_ptr_next  = (wrt_smpl && filled) ? old_ptr_reg + 1'b1 : old_ptr_reg;
    fill_cnt_next = (wrt_smpl && !filled) ? fill_cnt_reg + 1'b1 : fill_cnt_reg;
    state_next    = state_reg;
    pending_next  = 1'b0;
    start_seq     = 1'b0;

    case (state_reg)
      ST_FILL: begin
        if (wrt_smpl && (fill_cnt_reg == TAPS_M1_C)) begin
          start_seq  = 1'b1;
          state_next = ST_SEQ;
        end
      end
      ST_IDLE: begin
        if (wrt_smpl) begin
          start_seq  = 1'b1;
          state_next = ST_SEQ;
        end
      end
      ST_SEQ: begin
        if (last_rd) begin
          // A sample arriving in the final read cycle still needs its own
          // replay, so it restarts the sequence just like a pending request.
          if (pending_reg || wrt_smpl) begin
            start_seq  = 1'b1;
            state_next = ST_SEQ;
          end else begin
            state_next = ST_IDLE;
          end
          pending_next = pending_reg && wrt_smpl;
        end else begin
          pending_next = pending_reg || wrt_smpl;
        end
      end
      default: begin
        state_next = ST_FILL;
      end
    endcase

    // Replay starts from the post-update oldest sample
    if (start_seq) begin
      rd_ptr_next = old_ptr_next;
      rd_cnt_next = '0;
    end else if (rd_en) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
      rd_cnt_next = rd_cnt_reg + 1'b1;
    end else begin
      rd_ptr_next = rd_ptr_reg;
      rd_cnt_next = rd_cnt_reg;
    end
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_FILL;
      new_ptr_reg    <= '0;
      old_ptr_reg    <= '0;
      rd_ptr_reg     <= '0;
      fill_cnt_reg   <= '0;
      rd_cnt_reg     <= '0;
      pending_reg    <= 1'b0;
      last_rd_d1_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      new_ptr_reg    <= new_ptr_next;
      old_ptr_reg    <= old_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      fill_cnt_reg   <= fill_cnt_next;
      rd_cnt_reg     <= rd_cnt_next;
      pending_reg    <= pending_next;
      last_rd_d1_reg <= last_rd;
    end
  end

  // Sample storage write port; a write coincident with reset is dropped
  always_ff @(posedge clk) begin
    if (wrt_smpl && !rst) begin
      mem[new_ptr_reg] <= new_smpl;
    end
  end

  // Registered read port and output flags; smpl_out holds between sequences
  always_ff @(posedge clk) begin
    if (rst) begin
      smpl_out_reg   <= '0;
      sequencing_reg <= 1'b0;
      seq_done_reg   <= 1'b0;
    end else begin
      if (rd_en) begin
        smpl_out_reg <= mem[rd_ptr_reg];
      end
      sequencing_reg <= rd_en;
      seq_done_reg   <= last_rd_d1_reg;
    end
  end

  assign smpl_out   = smpl_out_reg;
  assign sequencing = sequencing_reg;
  assign seq_done   = seq_done_reg;

`ifdef SQ_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt_reg;
  logic       overrun;

  assign overrun = rd_en && wrt_smpl && pending_reg;

  // Saturating overrun counter, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_cnt_reg <= '0;
    end else if (overrun && (ovr_cnt_reg != 8'hFF)) begin
      ovr_cnt_reg <= ovr_cnt_reg + 8'd1;
    end
  end

  assign ovr_cnt = ovr_cnt_reg;
`endif

endmodule

// File: tb/tb_sample_queue.sv
// Directed testbench for sample_queue using a reduced buffer
// (DEPTH=32, TAPS=29) so every scenario runs in a few thousand cycles.
module tb_sample_queue;

  localparam int DEPTH = 32;
  localparam int TAPS  = 29;
  localparam int NWRAP = 70;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               wrt_smpl = 1'b0;
  logic signed [15:0] new_smpl = '0;
  logic signed [15:0] smpl_out;
  logic               sequencing;
  logic               seq_done;
`ifdef SQ_OVERRUN_CNT_EN
  logic [7:0]         ovr_cnt;
`endif

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  int                 seq_cyc_q[$];
  logic signed [15:0] seq_val_q[$];
  int                 done_q[$];

  sample_queue #(.DEPTH(DEPTH), .TAPS(TAPS)) dut (
    .clk        (clk),
    .rst        (rst),
    .wrt_smpl   (wrt_smpl),
    .new_smpl   (new_smpl),
    .smpl_out   (smpl_out),
    .sequencing (sequencing),
    .seq_done   (seq_done)
`ifdef SQ_OVERRUN_CNT_EN
    ,
    .ovr_cnt    (ovr_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every replayed sample and done pulse, sampled mid-cycle
  always @(negedge clk) begin
    if (sequencing === 1'b1) begin
      seq_cyc_q.push_back(cyc);
      seq_val_q.push_back(smpl_out);
    end
    if (seq_done === 1'b1) done_q.push_back(cyc);
  end

  task automatic clear_log();
    seq_cyc_q.delete();
    seq_val_q.delete();
    done_q.delete();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle write strobe; t returns the cycle in which the strobe was high
  task automatic do_write(input int v, output int t);
    @(posedge clk);
    #1;
    wrt_smpl = 1'b1;
    new_smpl = 16'(v);
    t = cyc;
    @(posedge clk);
    #1;
    wrt_smpl = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int t;
    @(posedge clk);
    #1;
    rst = 1'b1;
    wait_cycles(3);
    checks++;
    if (smpl_out !== 16'sd0) $display("FAIL reset_smpl_out: got %0d want 0", smpl_out);
    else passes++;
    checks++;
    if (sequencing !== 1'b0) $display("FAIL reset_sequencing: got %b want 0", sequencing);
    else passes++;
    checks++;
    if (seq_done !== 1'b0) $display("FAIL reset_seq_done: got %b want 0", seq_done);
    else passes++;
`ifdef SQ_OVERRUN_CNT_EN
    checks++;
    if (ovr_cnt !== 8'd0) $display("FAIL reset_ovr_cnt: got %0d want 0", ovr_cnt);
    else passes++;
`endif
    rst = 1'b0;
    t = 0;
    $display("test_reset: done");
  endtask

  task automatic test_fill();
    int t;
    int n;
    clear_log();
    for (int i = 0; i < TAPS - 1; i++) do_write(i, t);
    wait_cycles(4);
    checks++;
    if (seq_cyc_q.size() != 0 || done_q.size() != 0)
      $display("FAIL fill_no_seq: got %0d samples %0d done want 0 0", seq_cyc_q.size(), done_q.size());
    else passes++;
    clear_log();
    do_write(TAPS - 1, t);
    wait_cycles(TAPS + 5);
    checks++;
    if (seq_val_q.size() != TAPS) $display("FAIL fill_seq_len: got %0d want %0d", seq_val_q.size(), TAPS);
    else passes++;
    n = (seq_val_q.size() < TAPS) ? seq_val_q.size() : TAPS;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (seq_val_q[i] !== 16'(i) || seq_cyc_q[i] != t + 2 + i)
        $display("FAIL fill_sample[%0d]: got %0d at cyc %0d want %0d at cyc %0d", i, seq_val_q[i], seq_cyc_q[i], i, t + 2 + i);
      else passes++;
    end
    checks++;
    if (done_q.size() != 1 || done_q[0] != t + TAPS + 2)
      $display("FAIL fill_seq_done: got %0d pulses first %0d want 1 at %0d", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, t + TAPS + 2);
    else passes++;
    $display("test_fill: write at cyc %0d, %0d samples", t, seq_val_q.size());
  endtask

  task automatic test_idle_write();
    int t;
    int n;
    clear_log();
    do_write(TAPS, t);
    wait_cycles(TAPS + 5);
    checks++;
    if (seq_val_q.size() != TAPS) $display("FAIL idle_seq_len: got %0d want %0d", seq_val_q.size(), TAPS);
    else passes++;
    n = (seq_val_q.size() < TAPS) ? seq_val_q.size() : TAPS;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (seq_val_q[i] !== 16'(i + 1) || seq_cyc_q[i] != t + 2 + i)
        $display("FAIL idle_sample[%0d]: got %0d at cyc %0d want %0d at cyc %0d", i, seq_val_q[i], seq_cyc_q[i], i + 1, t + 2 + i);
      else passes++;
    end
    checks++;
    if (done_q.size() != 1 || done_q[0] != t + TAPS + 2)
      $display("FAIL idle_seq_done: got %0d pulses want 1 at %0d", done_q.size(), t + TAPS + 2);
    else passes++;
    $display("test_idle_write: write at cyc %0d, %0d samples", t, seq_val_q.size());
  endtask

  task automatic test_back_to_back();
    int t, t2, t3;
    int n;
    int exp_v;
    clear_log();
    do_write(TAPS + 1, t);
    wait_cycles(2);
    do_write(TAPS + 2, t2);
    do_write(TAPS + 3, t3);
    wait_cycles(2 * TAPS + 6);
    checks++;
    if (seq_val_q.size() != 2 * TAPS) $display("FAIL b2b_seq_len: got %0d want %0d", seq_val_q.size(), 2 * TAPS);
    else passes++;
    n = (seq_val_q.size() < 2 * TAPS) ? seq_val_q.size() : 2 * TAPS;
    for (int i = 0; i < n; i++) begin
      exp_v = (i < TAPS) ? i + 2 : i - TAPS + 4;
      checks++;
      if (seq_val_q[i] !== 16'(exp_v) || seq_cyc_q[i] != t + 2 + i)
        $display("FAIL b2b_sample[%0d]: got %0d at cyc %0d want %0d at cyc %0d", i, seq_val_q[i], seq_cyc_q[i], exp_v, t + 2 + i);
      else passes++;
    end
    checks++;
    if (done_q.size() != 2 || done_q[0] != t + TAPS + 2 || done_q[1] != t + 2 * TAPS + 2)
      $display("FAIL b2b_seq_done: got %0d pulses want 2 at %0d,%0d", done_q.size(), t + TAPS + 2, t + 2 * TAPS + 2);
    else passes++;
`ifdef SQ_OVERRUN_CNT_EN
    checks++;
    if (ovr_cnt !== 8'd1) $display("FAIL b2b_ovr_cnt: got %0d want 1", ovr_cnt);
    else passes++;
`endif
    $display("test_back_to_back: writes at cyc %0d,%0d,%0d, %0d samples", t, t2, t3, seq_val_q.size());
  endtask

  task automatic test_wrap();
    int t;
    int n;
    pulse_reset();
    for (int i = 0; i < TAPS - 1; i++) do_write(i, t);
    for (int v = TAPS - 1; v < NWRAP; v++) begin
      if (v == NWRAP - 1) clear_log();
      do_write(v, t);
      wait_cycles(TAPS + 4);
    end
    checks++;
    if (seq_val_q.size() != TAPS) $display("FAIL wrap_seq_len: got %0d want %0d", seq_val_q.size(), TAPS);
    else passes++;
    n = (seq_val_q.size() < TAPS) ? seq_val_q.size() : TAPS;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (seq_val_q[i] !== 16'(NWRAP - TAPS + i) || seq_cyc_q[i] != t + 2 + i)
        $display("FAIL wrap_sample[%0d]: got %0d at cyc %0d want %0d at cyc %0d", i, seq_val_q[i], seq_cyc_q[i], NWRAP - TAPS + i, t + 2 + i);
      else passes++;
    end
`ifdef SQ_OVERRUN_CNT_EN
    checks++;
    if (ovr_cnt !== 8'd0) $display("FAIL wrap_ovr_cnt: got %0d want 0", ovr_cnt);
    else passes++;
`endif
    $display("test_wrap: final write at cyc %0d, %0d samples", t, seq_val_q.size());
  endtask

  task automatic test_reset_mid();
    int t;
    int n;
    clear_log();
    do_write(NWRAP, t);
    wait_cycles(16);
    // Reset lands while sample index 16 would be replayed; the write alongside it must be dropped
    rst = 1'b1;
    wrt_smpl = 1'b1;
    new_smpl = 16'sd999;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wrt_smpl = 1'b0;
    checks++;
    if (seq_val_q.size() != 16) $display("FAIL rstmid_pre_len: got %0d want 16", seq_val_q.size());
    else passes++;
    checks++;
    if (sequencing !== 1'b0) $display("FAIL rstmid_sequencing: got %b want 0", sequencing);
    else passes++;
    checks++;
    if (smpl_out !== 16'sd0) $display("FAIL rstmid_smpl_out: got %0d want 0", smpl_out);
    else passes++;
    clear_log();
    for (int i = 0; i < TAPS - 1; i++) do_write(i - 50, t);
    wait_cycles(4);
    checks++;
    if (seq_cyc_q.size() != 0) $display("FAIL rstmid_refill_no_seq: got %0d samples want 0", seq_cyc_q.size());
    else passes++;
    do_write(TAPS - 1 - 50, t);
    wait_cycles(TAPS + 5);
    checks++;
    if (seq_val_q.size() != TAPS) $display("FAIL rstmid_seq_len: got %0d want %0d", seq_val_q.size(), TAPS);
    else passes++;
    n = (seq_val_q.size() < TAPS) ? seq_val_q.size() : TAPS;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (seq_val_q[i] !== 16'(i - 50))
        $display("FAIL rstmid_sample[%0d]: got %0d want %0d", i, seq_val_q[i], i - 50);
      else passes++;
    end
    $display("test_reset_mid: refill write at cyc %0d, %0d samples", t, seq_val_q.size());
  endtask

  initial begin
    test_reset();
    test_fill();
    test_idle_write();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
